// File: rtl/multicycle_main_ctrl.sv
// Multi-cycle main control: FETCH/DECODE/EXEC/WB sequencing and ALUOp decode.
// Define CTRL_ILLEGAL_TRAP_EN to make an illegal opcode a sticky trap state.
module multicycle_main_ctrl #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             instr_valid_i,
   input  logic [5:0]       opcode_i,
   input  logic             zero_i,
   output logic             instr_req_o,
   output logic             IRWrite_o,
   output logic             PCWrite_o,
   output logic             PCSrc_o,
   output logic [2:0]       ALUOp_o,
   output logic             ALUSrc_o,
   output logic             RegDst_o,
   output logic             RegWrite_o,
   output logic             illegal_o,
   output logic [CNT_W-1:0] retired_o
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_ILLEGAL
   } state_t;

   localparam logic [2:0] OP_R     = 3'b000;
   localparam logic [2:0] OP_ADDI  = 3'b001;
   localparam logic [2:0] OP_SLTIU = 3'b010;
   localparam logic [2:0] OP_BEQ   = 3'b011;
   localparam logic [2:0] OP_BNE   = 3'b100;
   localparam logic [2:0] OP_LUI   = 3'b101;
   localparam logic [2:0] OP_ORI   = 3'b110;

   state_t state;
   state_t state_nxt;

   logic [2:0]       aluop_q;
   logic             alusrc_q;
   logic             regdst_q;
   logic             illegal_q;
   logic [CNT_W-1:0] retired_q;

   logic [2:0] dec_aluop;
   logic       dec_alusrc;
   logic       dec_regdst;
   logic       dec_legal;

   logic req;
   logic irw;
   logic pcw;
   logic pcsrc;
   logic regw;
   logic retire;
   logic taken;

   always_comb begin
      dec_aluop  = OP_R;
      dec_alusrc = 1'b0;
      dec_regdst = 1'b0;
      dec_legal  = 1'b1;
      case (opcode_i)
         6'b000000: dec_regdst = 1'b1;
         6'b001000: begin
            dec_aluop  = OP_ADDI;
            dec_alusrc = 1'b1;
         end
         6'b001011: begin
            dec_aluop  = OP_SLTIU;
            dec_alusrc = 1'b1;
         end
         6'b000100: dec_aluop = OP_BEQ;
         6'b000101: dec_aluop = OP_BNE;
         6'b001111: begin
            dec_aluop  = OP_LUI;
            dec_alusrc = 1'b1;
         end
         6'b001101: begin
            dec_aluop  = OP_ORI;
            dec_alusrc = 1'b1;
         end
         default: dec_legal = 1'b0;
      endcase
   end

   // Branch class is recovered from the registered ALUOp.
   always_comb begin
      taken = 1'b0;
      if (aluop_q == OP_BEQ) taken = zero_i;
      if (aluop_q == OP_BNE) taken = !zero_i;
   end

   always_comb begin
      state_nxt = state;
      req       = 1'b0;
      irw       = 1'b0;
      pcw       = 1'b0;
      pcsrc     = 1'b0;
      regw      = 1'b0;
      retire    = 1'b0;
      case (state)
         S_FETCH: begin
            req = 1'b1;
            if (instr_valid_i) begin
               irw       = 1'b1;
               pcw       = 1'b1;
               state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            state_nxt = dec_legal ? S_EXEC : S_ILLEGAL;
         end
         S_EXEC: begin
            if (aluop_q == OP_BEQ || aluop_q == OP_BNE) begin
               pcw       = taken;
               pcsrc     = taken;
               retire    = 1'b1;
               state_nxt = S_FETCH;
            end else begin
               state_nxt = S_WB;
            end
         end
         S_WB: begin
            regw      = 1'b1;
            retire    = 1'b1;
            state_nxt = S_FETCH;
         end
         S_ILLEGAL: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_nxt = S_ILLEGAL;
`else
            retire    = 1'b1;
            state_nxt = S_FETCH;
`endif
         end
         default: state_nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= S_FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   // Datapath controls are only refreshed by a legal decode.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         aluop_q  <= OP_R;
         alusrc_q <= 1'b0;
         regdst_q <= 1'b0;
      end else if (state == S_DECODE && dec_legal) begin
         aluop_q  <= dec_aluop;
         alusrc_q <= dec_alusrc;
         regdst_q <= dec_regdst;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         illegal_q <= 1'b0;
      end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
         if (state == S_DECODE && !dec_legal) illegal_q <= 1'b1;
`else
         illegal_q <= (state == S_DECODE) && !dec_legal;
`endif
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         retired_q <= '0;
      end else if (retire) begin
         retired_q <= retired_q + CNT_W'(1);
      end
   end

   // Strobes are gated by reset so nothing leaks while it is held.
   assign instr_req_o = req & rst_i;
   assign IRWrite_o   = irw & rst_i;
   assign PCWrite_o   = pcw & rst_i;
   assign PCSrc_o     = pcsrc & rst_i;
   assign RegWrite_o  = regw & rst_i;
   assign ALUOp_o     = aluop_q;
   assign ALUSrc_o    = alusrc_q;
   assign RegDst_o    = regdst_q;
   assign illegal_o   = illegal_q;
   assign retired_o   = retired_q;

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// Scoreboard bench for multicycle_main_ctrl (CNT_W=4).
// Per-cycle expectations are queued at planning time and popped each cycle.
module tb_multicycle_main_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       instr_valid_i;
   logic [5:0] opcode_i;
   logic       zero_i;
   logic       instr_req_o;
   logic       IRWrite_o;
   logic       PCWrite_o;
   logic       PCSrc_o;
   logic [2:0] ALUOp_o;
   logic       ALUSrc_o;
   logic       RegDst_o;
   logic       RegWrite_o;
   logic       illegal_o;
   logic [3:0] retired_o;

   multicycle_main_ctrl #(.CNT_W(4)) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .instr_valid_i(instr_valid_i),
      .opcode_i(opcode_i),
      .zero_i(zero_i),
      .instr_req_o(instr_req_o),
      .IRWrite_o(IRWrite_o),
      .PCWrite_o(PCWrite_o),
      .PCSrc_o(PCSrc_o),
      .ALUOp_o(ALUOp_o),
      .ALUSrc_o(ALUSrc_o),
      .RegDst_o(RegDst_o),
      .RegWrite_o(RegWrite_o),
      .illegal_o(illegal_o),
      .retired_o(retired_o)
   );

   always #5 clk_i = ~clk_i;

   // strb = {req, irw, pcw, pcsrc, regw, illegal}
   typedef struct packed {
      logic       valid;
      logic       zero;
      logic [5:0] strb;
      logic [2:0] aluop;
      logic       alusrc;
      logic       regdst;
      logic [3:0] ret;
   } cyc_t;

   cyc_t sb[$];

   int checks = 0;
   int errors = 0;

   logic [2:0] m_aluop;
   logic       m_alusrc;
   logic       m_regdst;
   logic [3:0] m_ret;

   function automatic void model_reset();
      m_aluop  = 3'b000;
      m_alusrc = 1'b0;
      m_regdst = 1'b0;
      m_ret    = 4'd0;
   endfunction

   function automatic void push(logic v, logic z, logic [5:0] s);
      cyc_t e;
      e.valid  = v;
      e.zero   = z;
      e.strb   = s;
      e.aluop  = m_aluop;
      e.alusrc = m_alusrc;
      e.regdst = m_regdst;
      e.ret    = m_ret;
      sb.push_back(e);
   endfunction

   function automatic void plan_instr(logic [5:0] op, logic z, int waits);
      logic       legal;
      logic       br;
      logic       tk;
      legal = 1'b1;
      br    = 1'b0;
      tk    = 1'b0;
      for (int i = 0; i < waits; i++) push(1'b0, 1'b0, 6'b100000);
      push(1'b1, 1'b0, 6'b111000);
      push(1'b0, 1'b0, 6'b000000);
      case (op)
         6'b000000: begin m_aluop = 3'b000; m_alusrc = 0; m_regdst = 1; end
         6'b001000: begin m_aluop = 3'b001; m_alusrc = 1; m_regdst = 0; end
         6'b001011: begin m_aluop = 3'b010; m_alusrc = 1; m_regdst = 0; end
         6'b000100: begin m_aluop = 3'b011; m_alusrc = 0; m_regdst = 0;
                          br = 1; tk = z; end
         6'b000101: begin m_aluop = 3'b100; m_alusrc = 0; m_regdst = 0;
                          br = 1; tk = !z; end
         6'b001111: begin m_aluop = 3'b101; m_alusrc = 1; m_regdst = 0; end
         6'b001101: begin m_aluop = 3'b110; m_alusrc = 1; m_regdst = 0; end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
         for (int i = 0; i < 20; i++) push(1'b0, 1'b0, 6'b000001);
`else
         push(1'b0, 1'b0, 6'b000001);
         m_ret = m_ret + 4'd1;
`endif
      end else if (br) begin
         push(1'b0, z, tk ? 6'b001100 : 6'b000000);
         m_ret = m_ret + 4'd1;
      end else begin
         push(1'b0, z, 6'b000000);
         push(1'b0, 1'b0, 6'b000010);
         m_ret = m_ret + 4'd1;
      end
   endfunction

   task automatic run_sb(string name);
      cyc_t       e;
      logic [5:0] obs;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(posedge clk_i);
         #1;
         instr_valid_i = e.valid;
         zero_i        = e.zero;
         @(negedge clk_i);
         obs = {instr_req_o, IRWrite_o, PCWrite_o, PCSrc_o, RegWrite_o,
                illegal_o};
         checks++;
         if (obs !== e.strb) begin
            errors++;
            $display("FAIL %s strobes: got %b want %b", name, obs, e.strb);
         end
         checks++;
         if ({ALUOp_o, ALUSrc_o, RegDst_o} !== {e.aluop, e.alusrc, e.regdst})
         begin
            errors++;
            $display("FAIL %s alu ctl: got %b/%b/%b want %b/%b/%b", name,
                     ALUOp_o, ALUSrc_o, RegDst_o, e.aluop, e.alusrc,
                     e.regdst);
         end
         checks++;
         if (retired_o !== e.ret) begin
            errors++;
            $display("FAIL %s retired: got %0d want %0d", name, retired_o,
                     e.ret);
         end
      end
      instr_valid_i = 1'b0;
      zero_i        = 1'b0;
   endtask

   task automatic do_instr(string name, logic [5:0] op, logic z, int waits);
      opcode_i = op;
      plan_instr(op, z, waits);
      run_sb(name);
   endtask

   task automatic check_reset_vals(string name);
      checks++;
      if ({instr_req_o, IRWrite_o, PCWrite_o, PCSrc_o, RegWrite_o} !== 5'b0)
      begin
         errors++;
         $display("FAIL %s strobes: got %b want 00000", name,
                  {instr_req_o, IRWrite_o, PCWrite_o, PCSrc_o, RegWrite_o});
      end
      checks++;
      if ({ALUOp_o, ALUSrc_o, RegDst_o, illegal_o, retired_o} !== 10'b0)
      begin
         errors++;
         $display("FAIL %s regs: got aluop %b src %b dst %b ill %b ret %0d",
                  name, ALUOp_o, ALUSrc_o, RegDst_o, illegal_o, retired_o);
      end
   endtask

   task automatic release_reset(string name);
      @(negedge clk_i);
      rst_i = 1'b1;
      model_reset();
      #1;
      checks++;
      if (instr_req_o !== 1'b1) begin
         errors++;
         $display("FAIL %s fetch after reset: req %b want 1", name,
                  instr_req_o);
      end
   endtask

   task automatic test_reset();
      rst_i         = 1'b0;
      instr_valid_i = 1'b1;
      opcode_i      = 6'b000000;
      zero_i        = 1'b0;
      model_reset();
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check_reset_vals("reset");
      instr_valid_i = 1'b0;
      release_reset("reset");
   endtask

   task automatic test_r_type();
      do_instr("r_type", 6'b000000, 1'b0, 0);
   endtask

   task automatic test_addi_wait();
      do_instr("addi_wait", 6'b001000, 1'b0, 3);
   endtask

   task automatic test_branches();
      do_instr("beq_taken", 6'b000100, 1'b1, 0);
      do_instr("beq_not", 6'b000100, 1'b0, 1);
      do_instr("bne_taken", 6'b000101, 1'b0, 0);
      do_instr("bne_not", 6'b000101, 1'b1, 2);
   endtask

   task automatic test_alu_seq();
      do_instr("sltiu", 6'b001011, 1'b0, 0);
      do_instr("lui", 6'b001111, 1'b1, 0);
      do_instr("ori", 6'b001101, 1'b0, 1);
   endtask

   task automatic test_illegal();
      do_instr("illegal", 6'b111111, 1'b0, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
      rst_i = 1'b0;
      #1;
      check_reset_vals("trap_reset");
      release_reset("trap_reset");
`endif
      do_instr("after_illegal", 6'b000000, 1'b0, 0);
   endtask

   task automatic test_reset_wb();
      do_instr("pre_wb", 6'b001000, 1'b0, 0);
      #2;
      rst_i = 1'b0;
      #1;
      check_reset_vals("reset_wb");
      release_reset("reset_wb");
   endtask

   task automatic test_wrap();
      logic [5:0] ops[4];
      ops[0] = 6'b000000;
      ops[1] = 6'b001000;
      ops[2] = 6'b000100;
      ops[3] = 6'b000101;
      for (int i = 0; i < 15; i++)
         do_instr("wrap_fill", ops[i % 4], i[0], i % 3);
      do_instr("wrap_last", 6'b001101, 1'b0, 0);
      push(1'b0, 1'b0, 6'b100000);
      run_sb("wrap_idle");
      checks++;
      if (retired_o !== 4'd0) begin
         errors++;
         $display("FAIL wrap: retired %0d want 0", retired_o);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit hit, got running want finished");
      $display("Simulation finished: %0d checks, %0d errors", checks,
               errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_r_type();
      test_addi_wait();
      test_branches();
      test_alu_seq();
      test_illegal();
      test_reset_wb();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
